// File: rtl/joy_scan_pkg.sv
// Shared types and helpers for the DB9/JAMMA joystick chain scanner.
package joy_scan_pkg;

    typedef enum logic [2:0] {
        GAP,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } scan_state_t;

    // Longest chain the scanner accepts.
    localparam int MAX_BITS = 32;

    // Index width able to address the longest chain.
    localparam int MAX_IDX_W = $clog2(MAX_BITS);

    // System clocks per joy_clk half-period; zero flags an unusable rate.
    function automatic int calc_div(input int clk_hz, input int shift_hz);
        if (shift_hz <= 0) begin
            return 0;
        end
        return clk_hz / (2 * shift_hz);
    endfunction

    // Width of a counter that runs 0..n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/joy_shift_tick.sv
// Half-period timer: emits a one-cycle tick on the last cycle of every DIV-cycle window.
module joy_shift_tick
    import joy_scan_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = cnt_w(DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(DIV - 1));

    // Free-running window counter, restarted whenever the scanner changes state.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/joy_db9_scanner.sv
// Active scanner for a '165-style joystick shift-register chain.
// Drives joy_clk / joy_load_n from registers, captures NUM_BITS bits per scan,
// and publishes an active-high snapshot with a one-cycle scan_done strobe.
// Optional build macro JOY_PASSTHRU_EN adds legacy wire forwarding of an
// external chain master (xjoy_*), selected at run time by passthru_sel.
module joy_db9_scanner
    import joy_scan_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int SHIFT_HZ   = 1000000,
    parameter int NUM_BITS   = 16,
    parameter int GAP_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scan_en,
    output logic                joy_clk,
    output logic                joy_load_n,
    input  logic                joy_data,
    output logic [NUM_BITS-1:0] joy_state,
    output logic                scan_done
`ifdef JOY_PASSTHRU_EN
    ,
    input  logic                xjoy_clk,
    input  logic                xjoy_load_n,
    output logic                xjoy_data,
    input  logic                passthru_sel
`endif
);

    localparam int DIV   = calc_div(CLK_HZ, SHIFT_HZ);
    localparam int GAP_W = cnt_w(GAP_CYCLES);
    localparam int IDX_W = cnt_w(NUM_BITS);

    if (DIV < 1) begin : g_bad_div
        $error("joy_db9_scanner: CLK_HZ/(2*SHIFT_HZ) must be at least 1");
    end
    if (NUM_BITS < 1 || NUM_BITS > MAX_BITS) begin : g_bad_bits
        $error("joy_db9_scanner: NUM_BITS must be within 1..32");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("joy_db9_scanner: GAP_CYCLES must be at least 1");
    end

    scan_state_t         state;
    scan_state_t         next_state;
    logic [GAP_W-1:0]    gap_cnt;
    logic                gap_term;
    logic [IDX_W-1:0]    bit_idx;
    logic                bit_last;
    logic                load_half;
    logic                tick;
    logic                force_gap;
    logic [NUM_BITS-1:0] sr;
    logic                joy_data_p0;
    logic                joy_data_p1;
    logic                joy_clk_q;
    logic                joy_load_n_q;

`ifdef JOY_PASSTHRU_EN
    assign force_gap  = passthru_sel;
    assign xjoy_data  = joy_data;
    assign joy_clk    = passthru_sel ? xjoy_clk    : joy_clk_q;
    assign joy_load_n = passthru_sel ? xjoy_load_n : joy_load_n_q;
`else
    assign force_gap  = 1'b0;
    assign joy_clk    = joy_clk_q;
    assign joy_load_n = joy_load_n_q;
`endif

    assign gap_term = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign bit_last = (bit_idx == IDX_W'(NUM_BITS - 1));

    joy_shift_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (next_state != state),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= GAP;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; passthrough ownership parks the scanner in GAP.
    always_comb begin
        next_state = state;
        case (state)
            GAP:      if (gap_term && scan_en) next_state = LOAD;
            LOAD:     if (tick && load_half)   next_state = SHIFT_LO;
            SHIFT_LO: if (tick)                next_state = SHIFT_HI;
            SHIFT_HI: if (tick)                next_state = bit_last ? DONE : SHIFT_LO;
            DONE:                              next_state = GAP;
            default:                           next_state = GAP;
        endcase
        if (force_gap) begin
            next_state = GAP;
        end
    end

    // Gap, load-length and bit-index bookkeeping; the gap count saturates while waiting for scan_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt   <= '0;
            load_half <= 1'b0;
            bit_idx   <= '0;
        end else begin
            if (force_gap || state != GAP) begin
                gap_cnt <= '0;
            end else if (!gap_term) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (state != LOAD) begin
                load_half <= 1'b0;
            end else if (tick) begin
                load_half <= 1'b1;
            end

            if (state == LOAD) begin
                bit_idx <= '0;
            end else if (state == SHIFT_HI && tick && !bit_last) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous chain output.
    always_ff @(posedge clk) begin
        joy_data_p0 <= joy_data;
        joy_data_p1 <= joy_data_p0;
    end

    // Capture each bit on the last low half-period, just before joy_clk rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (state == SHIFT_LO && tick) begin
            sr[bit_idx] <= joy_data_p1;
        end
    end

    // Registered outputs, decoded from the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            joy_clk_q    <= 1'b0;
            joy_load_n_q <= 1'b1;
            joy_state    <= '0;
            scan_done    <= 1'b0;
        end else begin
            joy_clk_q    <= (next_state == SHIFT_HI);
            joy_load_n_q <= (next_state != LOAD);
            scan_done    <= (next_state == DONE);
            if (next_state == DONE) begin
                joy_state <= ~sr;
            end
        end
    end

endmodule

// File: tb/tb_joy_db9_scanner.sv
// Directed bench for joy_db9_scanner with a behavioural '165 chain model.
module tb_joy_db9_scanner;

    localparam int CLK_HZ   = 8;
    localparam int SHIFT_HZ = 2;
    localparam int NB       = 16;
    localparam int GAP      = 4;
    localparam int DIV      = 2;
    localparam int PERIOD   = GAP + 2 * DIV + 2 * DIV * NB + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          scan_en;
    logic          joy_clk;
    logic          joy_load_n;
    logic          joy_data;
    logic [NB-1:0] joy_state;
    logic          scan_done;
`ifdef JOY_PASSTHRU_EN
    logic          xjoy_clk;
    logic          xjoy_load_n;
    logic          xjoy_data;
    logic          passthru_sel;
    logic [NB-1:0] js_hold;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    joy_db9_scanner #(
        .CLK_HZ     (CLK_HZ),
        .SHIFT_HZ   (SHIFT_HZ),
        .NUM_BITS   (NB),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_en      (scan_en),
        .joy_clk      (joy_clk),
        .joy_load_n   (joy_load_n),
        .joy_data     (joy_data),
        .joy_state    (joy_state),
        .scan_done    (scan_done)
`ifdef JOY_PASSTHRU_EN
        ,
        .xjoy_clk     (xjoy_clk),
        .xjoy_load_n  (xjoy_load_n),
        .xjoy_data    (xjoy_data),
        .passthru_sel (passthru_sel)
`endif
    );

    // Chain model: parallel load while load_n is low, shift toward bit 0 on joy_clk rise.
    logic [NB-1:0] raw;
    logic [NB-1:0] chain = '1;
    logic          prev_jclk = 1'b0;
    always @(posedge clk) begin
        if (!joy_load_n) chain <= raw;
        else if (joy_clk && !prev_jclk) chain <= {1'b1, chain[NB-1:1]};
        prev_jclk <= joy_clk;
    end
    assign joy_data = chain[0];

    // joy_state must only move in a scan_done cycle.
    logic          mon_en = 1'b0;
    logic [NB-1:0] prev_js = '0;
    int            unstable = 0;
    always @(negedge clk) begin
        if (mon_en && !scan_done && joy_state != prev_js) unstable <= unstable + 1;
        prev_js <= joy_state;
    end

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Cycles until scan_done, counting the last reset/passthrough cycle as cycle 1.
    task automatic wait_done(output int cyc);
        cyc = 1;
        do begin
            @(negedge clk);
            cyc++;
        end while (!scan_done && cyc < 500);
        if (!scan_done) cyc = -1;
    endtask

    // One full scan measured from a scan_done cycle to the next.
    task automatic scan_once(output int period, output int lo, output int hi,
                             output int rises, output int badw);
        int   run;
        logic pc;
        period = 0; lo = 0; hi = 0; rises = 0; badw = 0; run = 0;
        pc = joy_clk;
        do begin
            @(negedge clk);
            period++;
            if (!joy_load_n) lo++;
            if (joy_clk) begin
                hi++;
                run++;
                if (!pc) rises++;
            end else begin
                if (pc && run != DIV) badw++;
                run = 0;
            end
            pc = joy_clk;
        end while (!scan_done && period < 500);
        if (!scan_done) period = -1;
    endtask

    task automatic wait_rises(input int n, output int got);
        int   guard;
        logic pc;
        got = 0; guard = 0;
        pc = joy_clk;
        while (got < n && guard < 500) begin
            @(negedge clk);
            guard++;
            if (joy_clk && !pc) got++;
            pc = joy_clk;
        end
    endtask

    initial begin
        int per, lo, hi, rises, badw, cyc, got, bad, dones;

        vecs[0] = '{16'hFFFE, 16'h0001};
        vecs[1] = '{16'hFFFF, 16'h0000};
        vecs[2] = '{16'h0000, 16'hFFFF};
        vecs[3] = '{16'h1234, 16'hEDCB};
        vecs[4] = '{16'hA5F0, 16'h5A0F};
        vecs[5] = '{16'h8001, 16'h7FFE};

        rst_n   = 1'b0;
        scan_en = 1'b1;
        raw     = 16'hA5F0;
`ifdef JOY_PASSTHRU_EN
        xjoy_clk     = 1'b0;
        xjoy_load_n  = 1'b1;
        passthru_sel = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_joy_clk", 32'(joy_clk), 32'd0);
        check("rst_load_n", 32'(joy_load_n), 32'd1);
        check("rst_state", 32'(joy_state), 32'd0);
        check("rst_done", 32'(scan_done), 32'd0);
        rst_n = 1'b1;

        // Basic scan: first result and its latency from reset.
        wait_done(cyc);
        check("first_latency", 32'(cyc), 32'(PERIOD));
        check("first_state", 32'(joy_state), 32'h5A0F);

        // Table of chain images, one full scan each.
        mon_en = 1'b1;
        for (int v = 0; v < 6; v++) begin
            raw = vecs[v].raw;
            scan_once(per, lo, hi, rises, badw);
            check($sformatf("v%0d_period", v), 32'(per), 32'(PERIOD));
            check($sformatf("v%0d_state", v), 32'(joy_state), 32'(vecs[v].exp));
            check($sformatf("v%0d_load_low", v), 32'(lo), 32'(2 * DIV));
            check($sformatf("v%0d_clk_high", v), 32'(hi), 32'(2 * NB));
            check($sformatf("v%0d_clk_rises", v), 32'(rises), 32'(NB));
            check($sformatf("v%0d_pulse_width", v), 32'(badw), 32'd0);
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("state_stable", 32'(unstable), 32'd0);

        // Reset during SHIFT_HI of bit 7 discards the scan entirely.
        raw = 16'hA5F0;
        wait_rises(8, got);
        check("reach_bit7", 32'(got), 32'd8);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_joy_clk", 32'(joy_clk), 32'd0);
        check("midrst_load_n", 32'(joy_load_n), 32'd1);
        check("midrst_state", 32'(joy_state), 32'd0);
        check("midrst_done", 32'(scan_done), 32'd0);
        rst_n = 1'b1;
        wait_done(cyc);
        check("midrst_latency", 32'(cyc), 32'(PERIOD));
        check("midrst_state_after", 32'(joy_state), 32'h5A0F);

        // scan_en gating from reset.
        raw     = 16'h1234;
        rst_n   = 1'b0;
        scan_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (!joy_load_n || joy_clk || scan_done) bad++;
        end
        check("gated_idle", 32'(bad), 32'd0);
        scan_en = 1'b1;
        @(negedge clk);
        check("gated_load_fall", 32'(joy_load_n), 32'd0);
        wait_rises(3, got);
        check("gated_reach_shift", 32'(got), 32'd3);
        scan_en = 1'b0;
        dones = 0;
        repeat (150) begin
            @(negedge clk);
            if (scan_done) dones++;
        end
        check("gated_done_count", 32'(dones), 32'd1);
        check("gated_state", 32'(joy_state), 32'hEDCB);

`ifdef JOY_PASSTHRU_EN
        // Passthrough mid-scan: abort, forward external master, then resume.
        raw     = 16'h00FF;
        scan_en = 1'b1;
        wait_rises(2, got);
        check("pt_reach_shift", 32'(got), 32'd2);
        js_hold      = joy_state;
        passthru_sel = 1'b1;
        dones = 0;
        for (int k = 0; k < 16; k++) begin
            xjoy_clk    = k[0];
            xjoy_load_n = k[1];
            #1;
            check("pt_joy_clk", 32'(joy_clk), 32'(xjoy_clk));
            check("pt_load_n", 32'(joy_load_n), 32'(xjoy_load_n));
            check("pt_xjoy_data", 32'(xjoy_data), 32'(joy_data));
            @(negedge clk);
            if (scan_done) dones++;
        end
        xjoy_clk    = 1'b0;
        xjoy_load_n = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (scan_done) dones++;
        end
        check("pt_no_done", 32'(dones), 32'd0);
        check("pt_state_kept", 32'(joy_state), 32'(js_hold));
        passthru_sel = 1'b0;
        wait_done(cyc);
        check("pt_resume_latency", 32'(cyc), 32'(PERIOD));
        check("pt_resume_state", 32'(joy_state), 32'hFF00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
